// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and field widths for the fetch stage
package fetch_pkg;

    localparam int INSTR_W    = 32;
    localparam int JUMP_IDX_W = 26;

    localparam logic [5:0] HALT_OPCODE_DEFAULT = 6'b111111;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational next-PC selection (jump, branch, sequential) and range check
module next_pc_calc
    import fetch_pkg::*;
#(
    parameter int ROM_BYTES = 256
) (
    input  logic [INSTR_W-1:0]    pc,
    input  logic                  branch_taken,
    input  logic [INSTR_W-1:0]    branch_offset,
    input  logic                  jump_taken,
    input  logic [JUMP_IDX_W-1:0] jump_target,
    output logic [INSTR_W-1:0]    pc_plus4,
    output logic [INSTR_W-1:0]    next_pc,
    output logic                  out_of_range
);

    localparam logic [INSTR_W-1:0] LAST_ADDR = INSTR_W'(ROM_BYTES - 4);

    assign pc_plus4 = pc + 32'd4;

    // Jump beats branch; all sums wrap modulo 2^32, so a negative wrap lands high and faults.
    always_comb begin
        next_pc = pc_plus4;
        if (jump_taken) begin
            next_pc = {pc_plus4[31:28], jump_target, 2'b00};
        end else if (branch_taken) begin
            next_pc = pc_plus4 + (branch_offset << 2);
        end
    end

    assign out_of_range = (next_pc > LAST_ADDR);

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register and fetch FSM; RETIRE_COUNT_EN adds the instr_count retire counter
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ROM_BYTES   = 256,
    parameter logic [5:0]  HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [INSTR_W-1:0]    rom_address,
    output logic                  rom_read_enable,
    input  logic [INSTR_W-1:0]    rom_read_data,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [INSTR_W-1:0]    branch_offset,
    input  logic                  jump_taken,
    input  logic [JUMP_IDX_W-1:0] jump_target,
    output logic [INSTR_W-1:0]    pc_out,
    output logic [INSTR_W-1:0]    pc_plus4,
    output logic [INSTR_W-1:0]    instr_out,
    output logic                  halted,
    output logic                  fault
`ifdef RETIRE_COUNT_EN
    ,
    output logic [31:0]           instr_count
`endif
);

    fetch_state_t       state, state_next;
    logic [INSTR_W-1:0] pc, pc_next;
    logic [INSTR_W-1:0] calc_next_pc;
    logic               calc_out_of_range;
    logic               is_halt_op;

    next_pc_calc #(
        .ROM_BYTES(ROM_BYTES)
    ) u_next_pc_calc (
        .pc           (pc),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .jump_taken   (jump_taken),
        .jump_target  (jump_target),
        .pc_plus4     (pc_plus4),
        .next_pc      (calc_next_pc),
        .out_of_range (calc_out_of_range)
    );

    assign is_halt_op = (rom_read_data[31:26] == HALT_OPCODE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_BOOT;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // A halting or faulting fetch leaves the PC on the offending instruction's address.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        case (state)
            ST_BOOT: state_next = ST_RUN;
            ST_RUN: begin
                if (!stall) begin
                    if (is_halt_op) begin
                        state_next = ST_HALT;
                    end else if (calc_out_of_range) begin
                        state_next = ST_FAULT;
                    end else begin
                        pc_next = calc_next_pc;
                    end
                end
            end
            default: state_next = state;
        endcase
    end

    assign pc_out          = pc;
    assign rom_address     = pc;
    assign rom_read_enable = (state == ST_RUN);
    assign instr_out       = (state == ST_RUN) ? rom_read_data : '0;
    assign halted          = (state == ST_HALT);
    assign fault           = (state == ST_FAULT);

`ifdef RETIRE_COUNT_EN
    logic        retire;
    logic [31:0] retire_count;

    // Faulting instructions retire; the halt instruction does not.
    assign retire = (state == ST_RUN) && !stall && !is_halt_op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_count <= 32'd0;
        end else if (retire) begin
            retire_count <= retire_count + 32'd1;
        end
    end

    assign instr_count = retire_count;
`endif

endmodule
